ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 129 ++++++++++++
 tb/tb_ex_mem_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, branch resolution,
// one-cycle PC redirect and a squash window for wrong-path EX results.
`ifndef SIZE
`define SIZE 64
`endif

module ex_mem_stage #(
  parameter int SIZE       = `SIZE,
  parameter int SQUASH_CNT = 2
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            exValid,
  output logic            exReady,
  input  logic [SIZE-1:0] aluOut,
  input  logic [SIZE-1:0] storeData,
  input  logic [4:0]      destReg,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic            regWrite,
  input  logic            isB,
  input  logic            isCbz,
  input  logic            isCbnz,
  input  logic            zeroIn,
  input  logic [SIZE-1:0] branchTarget,
  input  logic            flushIn,

  output logic            memValid,
  input  logic            memReady,
  output logic [SIZE-1:0] memAluOut,
  output logic [SIZE-1:0] memStoreData,
  output logic [4:0]      memDestReg,
  output logic            memRd,
  output logic            memWr,
  output logic            memRegWr,

  output logic            pcRedirect,
  output logic [SIZE-1:0] pcTarget
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUASH = 2'd1
  } stateT;

  stateT      state_r;
  logic [2:0] squashCount_r;

  logic transfer_s;
  logic isBranch_s;
  logic taken_s;
  logic lastSquash_s;

  // The slot frees up when empty or when MEM drains it this cycle.
  assign exReady = !memValid | memReady;

  // Handshake and branch-resolution decode.
  always_comb begin
    transfer_s   = exValid & exReady;
    isBranch_s   = isB | isCbz | isCbnz;
    taken_s      = isB | (isCbz & zeroIn) | (isCbnz & !zeroIn);
    lastSquash_s = (squashCount_r <= 3'd1);
  end

  // Pipeline register, redirect pulse and squash FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      squashCount_r <= 3'd0;
      memValid      <= 1'b0;
      memAluOut     <= {SIZE{1'b0}};
      memStoreData  <= {SIZE{1'b0}};
      memDestReg    <= 5'd0;
      memRd         <= 1'b0;
      memWr         <= 1'b0;
      memRegWr      <= 1'b0;
      pcRedirect    <= 1'b0;
      pcTarget      <= {SIZE{1'b0}};
    end else if (flushIn) begin
      // Flush wins over everything, including a same-cycle EX transfer.
      state_r       <= IDLE;
      squashCount_r <= 3'd0;
      memValid      <= 1'b0;
      pcRedirect    <= 1'b0;
    end else begin
      pcRedirect <= 1'b0;
      case (state_r)
        IDLE: begin
          if (transfer_s && !isBranch_s) begin
            memValid     <= 1'b1;
            memAluOut    <= aluOut;
            memStoreData <= storeData;
            memDestReg   <= destReg;
            memRd        <= memRead;
            memWr        <= memWrite;
            memRegWr     <= regWrite;
          end else if (memReady) begin
            memValid <= 1'b0;
          end
          if (transfer_s && isBranch_s && taken_s) begin
            pcRedirect    <= 1'b1;
            pcTarget      <= branchTarget;
            state_r       <= SQUASH;
            squashCount_r <= 3'(SQUASH_CNT);
          end
        end
        SQUASH: begin
          // Wrong-path results are swallowed; only real transfers count down.
          if (memReady) begin
            memValid <= 1'b0;
          end
          if (transfer_s) begin
            squashCount_r <= squashCount_r - 3'd1;
            if (lastSquash_s) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r       <= IDLE;
          squashCount_r <= 3'd0;
          memValid      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: streaming, backpressure, branches, squash,
// flush and mid-operation reset, all checked against hand-computed values.
module tb_ex_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        exValid;
  logic        exReady;
  logic [63:0] aluOut;
  logic [63:0] storeData;
  logic [4:0]  destReg;
  logic        memRead;
  logic        memWrite;
  logic        regWrite;
  logic        isB;
  logic        isCbz;
  logic        isCbnz;
  logic        zeroIn;
  logic [63:0] branchTarget;
  logic        flushIn;
  logic        memValid;
  logic        memReady;
  logic [63:0] memAluOut;
  logic [63:0] memStoreData;
  logic [4:0]  memDestReg;
  logic        memRd;
  logic        memWr;
  logic        memRegWr;
  logic        pcRedirect;
  logic [63:0] pcTarget;

  int checks = 0;
  int errors = 0;

  ex_mem_stage #(.SIZE(64), .SQUASH_CNT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .exValid(exValid), .exReady(exReady),
    .aluOut(aluOut), .storeData(storeData), .destReg(destReg),
    .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
    .isB(isB), .isCbz(isCbz), .isCbnz(isCbnz),
    .zeroIn(zeroIn), .branchTarget(branchTarget), .flushIn(flushIn),
    .memValid(memValid), .memReady(memReady),
    .memAluOut(memAluOut), .memStoreData(memStoreData), .memDestReg(memDestReg),
    .memRd(memRd), .memWr(memWr), .memRegWr(memRegWr),
    .pcRedirect(pcRedirect), .pcTarget(pcTarget)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    exValid = 1'b0; aluOut = 64'd0; storeData = 64'd0; destReg = 5'd0;
    memRead = 1'b0; memWrite = 1'b0; regWrite = 1'b0;
    isB = 1'b0; isCbz = 1'b0; isCbnz = 1'b0; zeroIn = 1'b0;
    branchTarget = 64'd0; flushIn = 1'b0;
  endtask

  task automatic addIn(input logic [63:0] v, input logic [4:0] rd);
    idleIn();
    exValid = 1'b1; aluOut = v; destReg = rd; regWrite = 1'b1;
  endtask

  task automatic brIn(input logic b, input logic cbz, input logic cbnz,
                      input logic z, input logic [63:0] tgt);
    idleIn();
    exValid = 1'b1; isB = b; isCbz = cbz; isCbnz = cbnz; zeroIn = z;
    branchTarget = tgt;
  endtask

  initial begin
    idleIn();
    memReady = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_memValid", memValid, 64'd0);
    chk("rst_pcRedirect", pcRedirect, 64'd0);
    chk("rst_memAluOut", memAluOut, 64'd0);
    chk("rst_pcTarget", pcTarget, 64'd0);
    chk("rst_exReady", exReady, 64'd1);
    #4 rst_n = 1'b1;

    // Stream of three ADDs.
    addIn(64'h10, 5'd1); tick();
    chk("str0_valid", memValid, 64'd1);
    chk("str0_alu", memAluOut, 64'h10);
    chk("str0_rd", memDestReg, 64'd1);
    chk("str0_regwr", memRegWr, 64'd1);
    addIn(64'h20, 5'd2); tick();
    chk("str1_valid", memValid, 64'd1);
    chk("str1_alu", memAluOut, 64'h20);
    addIn(64'h30, 5'd3); tick();
    chk("str2_valid", memValid, 64'd1);
    chk("str2_alu", memAluOut, 64'h30);
    idleIn(); tick();
    chk("str_drain", memValid, 64'd0);

    // Backpressure: load held while MEM stalls.
    addIn(64'h40, 5'd4); memRead = 1'b1; storeData = 64'hABCD; tick();
    chk("bp_load_alu", memAluOut, 64'h40);
    chk("bp_load_rd", memRd, 64'd1);
    chk("bp_load_sd", memStoreData, 64'hABCD);
    memReady = 1'b0; addIn(64'h50, 5'd5); #1;
    chk("bp_exReady0", exReady, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_alu", memAluOut, 64'h40);
      chk("bp_hold_valid", memValid, 64'd1);
    end
    memReady = 1'b1; #1;
    chk("bp_exReady1", exReady, 64'd1);
    tick();
    chk("bp_next_alu", memAluOut, 64'h50);
    chk("bp_next_rd", memRd, 64'd0);
    idleIn(); tick();
    chk("bp_drain", memValid, 64'd0);

    // CBZ taken, two squashed ADDs, then forwarded ADD.
    brIn(1'b0, 1'b1, 1'b0, 1'b1, 64'h200); tick();
    chk("cbz_redirect", pcRedirect, 64'd1);
    chk("cbz_target", pcTarget, 64'h200);
    chk("cbz_nofwd", memValid, 64'd0);
    addIn(64'hA1, 5'd6); tick();
    chk("cbz_pulse_end", pcRedirect, 64'd0);
    chk("cbz_target_hold", pcTarget, 64'h200);
    chk("sq_drop1", memValid, 64'd0);
    addIn(64'hA2, 5'd7); tick();
    chk("sq_drop2", memValid, 64'd0);
    addIn(64'h99, 5'd8); tick();
    chk("sq_after_valid", memValid, 64'd1);
    chk("sq_after_alu", memAluOut, 64'h99);

    // CBNZ with zeroIn=1 is not taken: bubble, no redirect.
    brIn(1'b0, 1'b0, 1'b1, 1'b1, 64'h300); tick();
    chk("cbnz_noredir", pcRedirect, 64'd0);
    chk("cbnz_bubble", memValid, 64'd0);
    chk("cbnz_target", pcTarget, 64'h200);

    // B taken, gaps in squash, second B in squash is consumed silently.
    brIn(1'b1, 1'b0, 1'b0, 1'b0, 64'h400); tick();
    chk("b_redirect", pcRedirect, 64'd1);
    chk("b_target", pcTarget, 64'h400);
    idleIn(); tick(); tick();
    addIn(64'hB1, 5'd9); tick();
    chk("gap_drop", memValid, 64'd0);
    idleIn(); tick();
    brIn(1'b1, 1'b0, 1'b0, 1'b0, 64'h500); tick();
    chk("b2_noredir", pcRedirect, 64'd0);
    chk("b2_target", pcTarget, 64'h400);
    addIn(64'hB3, 5'd10); tick();
    chk("b_after_valid", memValid, 64'd1);
    chk("b_after_alu", memAluOut, 64'hB3);

    // Flush with concurrent ADD and full MEM slot.
    addIn(64'hC1, 5'd11); flushIn = 1'b1; tick();
    chk("flush_valid", memValid, 64'd0);
    chk("flush_alu", memAluOut, 64'hB3);
    addIn(64'hC2, 5'd12); tick();
    chk("flush_idle_alu", memAluOut, 64'hC2);
    chk("flush_idle_valid", memValid, 64'd1);

    // Flush in the middle of a squash clears the counter.
    brIn(1'b1, 1'b0, 1'b0, 1'b0, 64'h700); tick();
    idleIn(); flushIn = 1'b1; tick();
    chk("flushsq_redir", pcRedirect, 64'd0);
    addIn(64'hD1, 5'd13); tick();
    chk("flushsq_fwd", memAluOut, 64'hD1);
    chk("flushsq_valid", memValid, 64'd1);

    // Reset during squash, right while the redirect pulse is high.
    brIn(1'b1, 1'b0, 1'b0, 1'b0, 64'h600); tick();
    chk("rst2_pre_redir", pcRedirect, 64'd1);
    idleIn();
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_valid", memValid, 64'd0);
    chk("rst2_redir", pcRedirect, 64'd0);
    chk("rst2_target", pcTarget, 64'd0);
    chk("rst2_alu", memAluOut, 64'd0);
    chk("rst2_rd", memDestReg, 64'd0);
    chk("rst2_exReady", exReady, 64'd1);
    #2 rst_n = 1'b1;
    addIn(64'hF1, 5'd14); tick();
    chk("rst2_fwd_valid", memValid, 64'd1);
    chk("rst2_fwd_alu", memAluOut, 64'hF1);
    chk("rst2_fwd_rd", memDestReg, 64'd14);
    idleIn(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
